// File: rtl/ow_byte_master_if.sv
// Command/status bundle between the SPI command decoder and the 1-Wire byte master.
// The decoder drives the master modport; the byte master uses the slave modport.
interface ow_byte_master_if;
    logic       reset;
    logic       write_byte;
    logic       read_byte;
    logic [7:0] in_byte;
    logic [7:0] out_byte;
    logic       presense;
    logic       busy;
    logic       done;

    modport master (
        output reset, write_byte, read_byte, in_byte,
        input  out_byte, presense, busy, done
    );

    modport slave (
        input  reset, write_byte, read_byte, in_byte,
        output out_byte, presense, busy, done
    );
endinterface

// File: rtl/ow_byte_master.sv
// Byte-level standard-speed 1-Wire master: reset/presence, write-byte and read-byte
// sequences built from a microsecond prescaler, driving an open-drain bus line.
module ow_byte_master #(
    parameter int CLKS_PER_US = 50
) (
    input  logic             clk,
    input  logic             rst,
    ow_byte_master_if.slave  cmd,
    output logic             wire_out,
    input  logic             wire_in
);

    localparam int PRE_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_US - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RST_LOW  = 4'd1,
        S_RST_WAIT = 4'd2,
        S_RST_REC  = 4'd3,
        S_WR_LOW   = 4'd4,
        S_WR_REL   = 4'd5,
        S_RD_LOW   = 4'd6,
        S_RD_WAIT  = 4'd7,
        S_RD_REC   = 4'd8,
        S_DONE     = 4'd9
    } state_t;

    state_t           state_r;
    state_t           next_s;
    logic [PRE_W-1:0] pre_r;
    logic [9:0]       t_r;
    logic [9:0]       lim_s;
    logic [2:0]       idx_r;
    logic [7:0]       tx_r;
    logic [7:0]       rx_r;
    logic             rd_op_r;
    logic             sync1_r;
    logic             sync2_r;
    logic             wire_out_r;
    logic             busy_r;
    logic             done_r;
    logic             presense_r;
    logic [7:0]       out_byte_r;
    logic             wire_s;
    logic             busy_s;
    logic             done_s;
    logic             tick_s;
    logic             at_lim_s;
    logic             enter_s;
    logic             accept_s;

    assign tick_s   = (pre_r == PRE_LAST);
    assign at_lim_s = tick_s && (t_r == lim_s);
    assign enter_s  = (next_s != state_r);
    assign accept_s = (state_r == S_IDLE) && (next_s != S_IDLE);

    assign wire_out     = wire_out_r;
    assign cmd.busy     = busy_r;
    assign cmd.done     = done_r;
    assign cmd.presense = presense_r;
    assign cmd.out_byte = out_byte_r;

    // Two-flop synchronizer for the asynchronous bus readback; idles released (high).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= wire_in;
            sync2_r <= sync1_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Last microsecond index of the current state; write phases depend on the bit value.
    always_comb begin
        lim_s = 10'd0;
        case (state_r)
            S_RST_LOW:  lim_s = 10'd479;
            S_RST_WAIT: lim_s = 10'd69;
            S_RST_REC:  lim_s = 10'd409;
            S_WR_LOW:   lim_s = tx_r[idx_r] ? 10'd5 : 10'd59;
            S_WR_REL:   lim_s = tx_r[idx_r] ? 10'd63 : 10'd9;
            S_RD_LOW:   lim_s = 10'd5;
            S_RD_WAIT:  lim_s = 10'd8;
            S_RD_REC:   lim_s = 10'd54;
            default:    lim_s = 10'd0;
        endcase
    end

    // Next-state logic; commands are only looked at in IDLE, reset has top priority.
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (cmd.reset)           next_s = S_RST_LOW;
                else if (cmd.write_byte) next_s = S_WR_LOW;
                else if (cmd.read_byte)  next_s = S_RD_LOW;
                else                     next_s = S_IDLE;
            end
            S_RST_LOW:  next_s = at_lim_s ? S_RST_WAIT : S_RST_LOW;
            S_RST_WAIT: next_s = at_lim_s ? S_RST_REC  : S_RST_WAIT;
            S_RST_REC:  next_s = at_lim_s ? S_DONE     : S_RST_REC;
            S_WR_LOW:   next_s = at_lim_s ? S_WR_REL   : S_WR_LOW;
            S_WR_REL: begin
                if (!at_lim_s)           next_s = S_WR_REL;
                else if (idx_r == 3'd7)  next_s = S_DONE;
                else                     next_s = S_WR_LOW;
            end
            S_RD_LOW:   next_s = at_lim_s ? S_RD_WAIT : S_RD_LOW;
            S_RD_WAIT:  next_s = at_lim_s ? S_RD_REC  : S_RD_WAIT;
            S_RD_REC: begin
                if (!at_lim_s)           next_s = S_RD_REC;
                else if (idx_r == 3'd7)  next_s = S_DONE;
                else                     next_s = S_RD_LOW;
            end
            S_DONE:     next_s = S_IDLE;
            default:    next_s = S_IDLE;
        endcase
    end

    // Output decode; busy stays up through the done cycle so it falls one edge later.
    always_comb begin
        wire_s = 1'b1;
        case (state_r)
            S_RST_LOW, S_WR_LOW, S_RD_LOW: wire_s = 1'b0;
            default:                       wire_s = 1'b1;
        endcase
        busy_s = (state_r != S_IDLE) || done_r;
        done_s = (state_r == S_DONE);
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wire_out_r <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            wire_out_r <= wire_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    // Prescaler and microsecond counter restart on every state entry for exact intervals.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_r <= {PRE_W{1'b0}};
            t_r   <= 10'd0;
        end else if (enter_s || (state_r == S_IDLE)) begin
            pre_r <= {PRE_W{1'b0}};
            t_r   <= 10'd0;
        end else if (tick_s) begin
            pre_r <= {PRE_W{1'b0}};
            t_r   <= t_r + 10'd1;
        end else begin
            pre_r <= pre_r + PRE_ONE;
        end
    end

    // Operation datapath: byte latch, bit index, read shift, presence and result byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r      <= 3'd0;
            tx_r       <= 8'h00;
            rx_r       <= 8'h00;
            rd_op_r    <= 1'b0;
            presense_r <= 1'b0;
            out_byte_r <= 8'h00;
        end else begin
            if (accept_s) begin
                tx_r    <= cmd.in_byte;
                idx_r   <= 3'd0;
                rd_op_r <= (next_s == S_RD_LOW);
            end else if (at_lim_s && ((state_r == S_WR_REL) || (state_r == S_RD_REC))) begin
                idx_r <= idx_r + 3'd1;
            end
            if (accept_s && (next_s == S_RST_LOW)) begin
                presense_r <= 1'b0;
            end else if ((state_r == S_RST_WAIT) && at_lim_s) begin
                presense_r <= ~sync2_r;
            end
            if ((state_r == S_RD_WAIT) && at_lim_s) begin
                rx_r[idx_r] <= sync2_r;
            end
            if ((state_r == S_DONE) && rd_op_r) begin
                out_byte_r <= rx_r;
            end
        end
    end

endmodule

// File: tb/tb_ow_byte_master.sv
// Self-checking bench for ow_byte_master with a behavioural 1-Wire slave on the bus.
module tb_ow_byte_master;
    localparam int C = 4;

    logic clk;
    logic rst;
    logic wire_out;
    logic wire_in;

    ow_byte_master_if bus_if();

    ow_byte_master #(.CLKS_PER_US(C)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (bus_if),
        .wire_out (wire_out),
        .wire_in  (wire_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Device controls (driven by the stimulus process only)
    bit       dev_present = 1'b0;
    bit       dev_rd_en   = 1'b0;
    bit       dev_stuck   = 1'b0;
    logic [7:0] dev_rd_bits = 8'h00;

    // Monitor / device state (written by the negedge process only)
    bit       prev_wo    = 1'b1;
    bit       dev_pull   = 1'b0;
    int       low_cnt    = 0;
    int       cyc        = 0;
    int       pull_left  = 0;
    int       pres_delay = 0;
    logic [2:0] rd_idx   = 3'd0;
    int       pulse_q[$];
    int       fall_q[$];

    assign wire_in = wire_out & ~dev_pull;

    // Bus monitor and slave model
    always @(negedge clk) begin
        cyc     <= cyc + 1;
        prev_wo <= wire_out;
        if (!wire_out) low_cnt <= prev_wo ? 1 : low_cnt + 1;
        if (prev_wo && !wire_out) fall_q.push_back(cyc);
        if (!prev_wo && wire_out) pulse_q.push_back(low_cnt);
        if (dev_stuck) dev_pull <= 1'b1;
        else if (pull_left > 0) begin
            pull_left <= pull_left - 1;
            dev_pull  <= (pull_left > 1);
        end else if (pres_delay > 0) begin
            pres_delay <= pres_delay - 1;
            if (pres_delay == 1) begin
                dev_pull  <= 1'b1;
                pull_left <= 120 * C;
            end
        end else dev_pull <= 1'b0;
        if (!dev_rd_en) rd_idx <= 3'd0;
        else if (prev_wo && !wire_out) begin
            rd_idx <= rd_idx + 3'd1;
            if (!dev_rd_bits[rd_idx]) begin
                dev_pull  <= 1'b1;
                pull_left <= 30 * C;
            end
        end
        if (!prev_wo && wire_out && dev_present && (low_cnt >= 400 * C)) pres_delay <= 30 * C;
    end

    int pass_cnt = 0;
    int total_cnt = 0;
    int exp_pulse_q[$];
    logic [7:0] exp_byte_q[$];
    logic [7:0] model_out = 8'h00;

    bit pre_busy_v, pre_wo_v, pre_pres_v, post_busy_v, post_wo_v, fin_v;
    int busy_cyc_v, dones_v;
    logic [7:0] done_byte_v;

    task automatic run_op(input bit r, input bit w, input bit rd, input logic [7:0] b, input int inj_at);
        @(negedge clk);
        bus_if.reset = r; bus_if.write_byte = w; bus_if.read_byte = rd; bus_if.in_byte = b;
        @(negedge clk);
        bus_if.reset = 1'b0; bus_if.write_byte = 1'b0; bus_if.read_byte = 1'b0; bus_if.in_byte = ~b;
        pre_busy_v = bus_if.busy; pre_wo_v = wire_out; pre_pres_v = bus_if.presense;
        fin_v = 1'b0; busy_cyc_v = 0; dones_v = 0; done_byte_v = 8'h00;
        for (int i = 0; i < 6000; i++) begin
            bus_if.reset = (i == inj_at);
            @(negedge clk);
            if (i == 0) begin post_busy_v = bus_if.busy; post_wo_v = wire_out; end
            if (bus_if.busy) busy_cyc_v++;
            if (bus_if.done) begin dones_v++; done_byte_v = bus_if.out_byte; end
            if (!bus_if.busy) begin fin_v = 1'b1; break; end
        end
        bus_if.reset = 1'b0;
    endtask

    task automatic test_reset_state();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (wire_out !== 1'b1) $display("FAIL rst_wire: got %0b want 1", wire_out); else pass_cnt++;
        total_cnt++; if (bus_if.busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", bus_if.busy); else pass_cnt++;
        total_cnt++; if (bus_if.done !== 1'b0) $display("FAIL rst_done: got %0b want 0", bus_if.done); else pass_cnt++;
        total_cnt++; if (bus_if.presense !== 1'b0) $display("FAIL rst_pres: got %0b want 0", bus_if.presense); else pass_cnt++;
        total_cnt++; if (bus_if.out_byte !== 8'h00) $display("FAIL rst_out: got %h want 00", bus_if.out_byte); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_presence();
        int base;
        dev_present = 1'b1;
        base = pulse_q.size();
        exp_pulse_q.push_back(480 * C);
        run_op(1'b1, 1'b0, 1'b0, 8'h00, -1);
        total_cnt++; if (pre_busy_v !== 1'b0 || pre_wo_v !== 1'b1) $display("FAIL accept_early: busy=%0b wire=%0b want 0/1", pre_busy_v, pre_wo_v); else pass_cnt++;
        total_cnt++; if (post_busy_v !== 1'b1 || post_wo_v !== 1'b0) $display("FAIL accept_n1: busy=%0b wire=%0b want 1/0", post_busy_v, post_wo_v); else pass_cnt++;
        total_cnt++; if (fin_v !== 1'b1) $display("FAIL pres_timeout: finished=%0b want 1", fin_v); else pass_cnt++;
        total_cnt++; if (busy_cyc_v !== 960 * C + 2) $display("FAIL pres_busy: got %0d want %0d", busy_cyc_v, 960 * C + 2); else pass_cnt++;
        total_cnt++; if (dones_v !== 1) $display("FAIL pres_done: got %0d want 1", dones_v); else pass_cnt++;
        total_cnt++; if (pulse_q.size() - base !== 1) $display("FAIL pres_npulse: got %0d want 1", pulse_q.size() - base); else pass_cnt++;
        begin
            int got, want;
            want = exp_pulse_q.pop_front();
            got = (pulse_q.size() > base) ? pulse_q[base] : -1;
            total_cnt++; if (got !== want) $display("FAIL pres_low: got %0d want %0d", got, want); else pass_cnt++;
        end
        total_cnt++; if (bus_if.presense !== 1'b1) $display("FAIL pres_flag: got %0b want 1", bus_if.presense); else pass_cnt++;
    endtask

    task automatic test_read();
        logic [7:0] pats [2];
        pats[0] = 8'h3C; pats[1] = 8'hA7;
        for (int p = 0; p < 2; p++) begin
            int base;
            base = pulse_q.size();
            dev_rd_bits = pats[p];
            dev_rd_en = 1'b1;
            exp_byte_q.push_back(pats[p]);
            model_out = pats[p];
            for (int k = 0; k < 8; k++) exp_pulse_q.push_back(6 * C);
            run_op(1'b0, 1'b0, 1'b1, 8'h00, -1);
            dev_rd_en = 1'b0;
            total_cnt++; if (fin_v !== 1'b1 || dones_v !== 1) $display("FAIL rd_done: fin=%0b dones=%0d want 1/1", fin_v, dones_v); else pass_cnt++;
            total_cnt++; if (busy_cyc_v !== 560 * C + 2) $display("FAIL rd_busy: got %0d want %0d", busy_cyc_v, 560 * C + 2); else pass_cnt++;
            begin
                logic [7:0] want_b;
                want_b = exp_byte_q.pop_front();
                total_cnt++; if (done_byte_v !== want_b) $display("FAIL rd_byte: got %h want %h", done_byte_v, want_b); else pass_cnt++;
            end
            for (int k = 0; k < 8; k++) begin
                int got, want;
                want = exp_pulse_q.pop_front();
                got = (pulse_q.size() > base + k) ? pulse_q[base + k] : -1;
                total_cnt++; if (got !== want) $display("FAIL rd_pulse%0d: got %0d want %0d", k, got, want); else pass_cnt++;
            end
        end
    endtask

    task automatic test_write(input logic [7:0] b, input bit both, input int inj_at);
        int base, fbase;
        base = pulse_q.size();
        fbase = fall_q.size();
        for (int k = 0; k < 8; k++) exp_pulse_q.push_back(b[k] ? 6 * C : 60 * C);
        run_op(1'b0, 1'b1, both, b, inj_at);
        total_cnt++; if (fin_v !== 1'b1 || dones_v !== 1) $display("FAIL wr_done: fin=%0b dones=%0d want 1/1", fin_v, dones_v); else pass_cnt++;
        total_cnt++; if (busy_cyc_v !== 560 * C + 2) $display("FAIL wr_busy: got %0d want %0d", busy_cyc_v, 560 * C + 2); else pass_cnt++;
        total_cnt++; if (pulse_q.size() - base !== 8) $display("FAIL wr_npulse: got %0d want 8", pulse_q.size() - base); else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            int got, want;
            want = exp_pulse_q.pop_front();
            got = (pulse_q.size() > base + k) ? pulse_q[base + k] : -1;
            total_cnt++; if (got !== want) $display("FAIL wr_pulse%0d: got %0d want %0d", k, got, want); else pass_cnt++;
        end
        for (int k = 1; k < 8; k++) begin
            int gap;
            gap = (fall_q.size() > fbase + k) ? fall_q[fbase + k] - fall_q[fbase + k - 1] : -1;
            total_cnt++; if (gap !== 70 * C) $display("FAIL wr_slot%0d: got %0d want %0d", k, gap, 70 * C); else pass_cnt++;
        end
        total_cnt++; if (bus_if.out_byte !== model_out) $display("FAIL wr_outkeep: got %h want %h", bus_if.out_byte, model_out); else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++; if (bus_if.busy !== 1'b0) $display("FAIL wr_noqueue: busy=%0b want 0", bus_if.busy); else pass_cnt++;
    endtask

    task automatic test_no_device();
        dev_present = 1'b0;
        total_cnt++; if (bus_if.presense !== 1'b1) $display("FAIL nodev_prior: got %0b want 1", bus_if.presense); else pass_cnt++;
        run_op(1'b1, 1'b0, 1'b0, 8'h00, -1);
        total_cnt++; if (pre_pres_v !== 1'b0) $display("FAIL nodev_clear: got %0b want 0", pre_pres_v); else pass_cnt++;
        total_cnt++; if (fin_v !== 1'b1 || busy_cyc_v !== 960 * C + 2) $display("FAIL nodev_busy: got %0d want %0d", busy_cyc_v, 960 * C + 2); else pass_cnt++;
        total_cnt++; if (bus_if.presense !== 1'b0) $display("FAIL nodev_pres: got %0b want 0", bus_if.presense); else pass_cnt++;
        total_cnt++; if (bus_if.out_byte !== model_out) $display("FAIL nodev_out: got %h want %h", bus_if.out_byte, model_out); else pass_cnt++;
    endtask

    task automatic test_stuck_low();
        dev_stuck = 1'b1;
        run_op(1'b1, 1'b0, 1'b0, 8'h00, -1);
        total_cnt++; if (bus_if.presense !== 1'b1) $display("FAIL stuck_pres: got %0b want 1", bus_if.presense); else pass_cnt++;
        exp_byte_q.push_back(8'h00);
        model_out = 8'h00;
        run_op(1'b0, 1'b0, 1'b1, 8'h00, -1);
        begin
            logic [7:0] want_b;
            want_b = exp_byte_q.pop_front();
            total_cnt++; if (fin_v !== 1'b1 || done_byte_v !== want_b) $display("FAIL stuck_byte: got %h want %h", done_byte_v, want_b); else pass_cnt++;
        end
        dev_stuck = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_rst_mid();
        int dones;
        bit went_low;
        @(negedge clk);
        bus_if.write_byte = 1'b1; bus_if.in_byte = 8'hFF;
        @(negedge clk);
        bus_if.write_byte = 1'b0;
        repeat (3 * 70 * C + 40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++; if (wire_out !== 1'b1) $display("FAIL mid_wire: got %0b want 1", wire_out); else pass_cnt++;
        total_cnt++; if (bus_if.busy !== 1'b0) $display("FAIL mid_busy: got %0b want 0", bus_if.busy); else pass_cnt++;
        total_cnt++; if (bus_if.out_byte !== 8'h00) $display("FAIL mid_out: got %h want 00", bus_if.out_byte); else pass_cnt++;
        model_out = 8'h00;
        dones = 0; went_low = 1'b0;
        repeat (800) begin
            @(negedge clk);
            if (bus_if.done) dones++;
            if (!wire_out) went_low = 1'b1;
        end
        total_cnt++; if (dones !== 0 || went_low !== 1'b0) $display("FAIL mid_quiet: dones=%0d low=%0b want 0/0", dones, went_low); else pass_cnt++;
        dev_rd_bits = 8'h81;
        dev_rd_en = 1'b1;
        exp_byte_q.push_back(8'h81);
        model_out = 8'h81;
        run_op(1'b0, 1'b0, 1'b1, 8'h00, -1);
        dev_rd_en = 1'b0;
        begin
            logic [7:0] want_b;
            want_b = exp_byte_q.pop_front();
            total_cnt++; if (fin_v !== 1'b1 || dones_v !== 1 || done_byte_v !== want_b) $display("FAIL mid_next: got %h dones=%0d want %h/1", done_byte_v, dones_v, want_b); else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_if.reset = 1'b0; bus_if.write_byte = 1'b0; bus_if.read_byte = 1'b0; bus_if.in_byte = 8'h00;
        test_reset_state();
        test_presence();
        test_read();
        test_write(8'hA5, 1'b0, -1);
        test_no_device();
        test_write(8'h5A, 1'b1, 500);
        test_stuck_low();
        test_rst_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
